// File: rtl/ksa29_burst_accumulator_if.sv
// ksa29_burst_accumulator_if: beat input and result output bundle for the burst accumulator
// in_valid/in_ready/in_data/in_last: 29-bit operand stream; in_last closes a burst
// out_valid/out_ready/out_sum/out_count/out_ovf: burst total {hi,lo}, beat count, wrap flag
interface ksa29_burst_accumulator_if #(parameter int CNTW = 8) ();
  logic in_valid;
  logic in_ready;
  logic [28:0] in_data;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic [28+CNTW:0] out_sum;
  logic [CNTW:0] out_count;
  logic out_ovf;
  modport slave (input in_valid, in_data, in_last, out_ready, output in_ready, out_valid, out_sum, out_count, out_ovf);
  modport master (output in_valid, in_data, in_last, out_ready, input in_ready, out_valid, out_sum, out_count, out_ovf);
endinterface

// File: rtl/ksa29_burst_accumulator.sv
// ksa29_burst_accumulator: sums a burst of 29-bit words through a 29-bit Kogge-Stone core
// CLK/RST: clock and asynchronous active-high reset
// bus (slave): beat stream in, {hi,lo} total with beat count and overflow flag out
module ksa29 (
  input  logic [28:0] x,
  input  logic [28:0] y,
  input  logic        ci,
  output logic [29:0] s
);
  logic [28:0] g [6];
  logic [28:0] p [6];
  logic [28:0] c;
  assign g[0] = x & y;
  assign p[0] = x ^ y;
  for (genvar l = 0; l < 5; l++) begin : g_lvl
    for (genvar i = 0; i < 29; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_op
        assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
        assign p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
      end else begin : g_pass
        assign g[l+1][i] = g[l][i];
        assign p[l+1][i] = p[l][i];
      end
    end
  end
  assign c = g[5] | (p[5] & {29{ci}});
  assign s = {c[28], p[0] ^ {c[27:0], ci}};
endmodule

module ksa29_burst_accumulator #(parameter int CNTW = 8) (
  input logic CLK,
  input logic RST,
  ksa29_burst_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  localparam logic [CNTW:0] SAT = (CNTW+1)'((1 << CNTW) + 1);
  state_t state_q, state_d;
  logic [28:0] lo_q, lo_d;
  logic [CNTW-1:0] hi_q, hi_d;
  logic [CNTW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic rdy_q, rdy_d;
  logic acc, clr;
  logic [29:0] s;
  ksa29 u_ksa (.x(lo_q), .y(bus.in_data), .ci(1'b0), .s(s));
  // in_ready is registered from the next state so it is low during reset and never follows out_ready
  always_comb begin
    acc = rdy_q & bus.in_valid;
    clr = (state_q == DONE) & bus.out_ready;
    lo_d = clr ? '0 : acc ? s[28:0] : lo_q;
    hi_d = clr ? '0 : acc ? hi_q + CNTW'(s[29]) : hi_q;
    cnt_d = clr ? '0 : (acc && cnt_q != SAT) ? cnt_q + (CNTW+1)'(1) : cnt_q;
    ovf_d = clr ? 1'b0 : ovf_q | (acc & cnt_q[CNTW]);
    state_d = clr ? IDLE : acc ? (bus.in_last ? DONE : ACC) : state_q;
    rdy_d = state_d != DONE;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      lo_q <= '0;
      hi_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      rdy_q <= rdy_d;
    end
  assign bus.in_ready = rdy_q;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_sum = {hi_q, lo_q};
  assign bus.out_count = cnt_q;
  assign bus.out_ovf = ovf_q;
endmodule
